// File: rtl/cdc_pkg.sv
// Shared constants for the toggle-based clock-domain-crossing receivers.
package cdc_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage : cdc_pkg

// File: rtl/cdc_sync_bit.sv
// Single-bit, STAGES-deep synchroniser. No reset, so it keeps flushing while the domain is in reset.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic d,
  output logic q
);
  import cdc_pkg::*;

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_sync_bit: STAGES below MIN_SYNC_STAGES");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/cdc_sync_bus_rx.sv
// Receive side of a multi-channel toggle CDC: synchronise each event toggle, capture the
// quasi-static bus, present it on valid/ready and return an ack toggle per consumed word.
module cdc_sync_bus_rx #(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     toggle_in,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     data_in,
  output logic [NUM_CH-1:0]                     valid_out,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]     data_out,
  input  logic [NUM_CH-1:0]                     ready_in,
  output logic [NUM_CH-1:0]                     ack_toggle,
  output logic [NUM_CH-1:0]                     overflow,
  input  logic [NUM_CH-1:0]                     clr_ovf
);
  import cdc_pkg::*;

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_sync_bus_rx: SYNC_STAGES below MIN_SYNC_STAGES");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                  tog_sync;
    logic                  ev;
    logic                  hs;
    logic                  prev_q,  prev_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  ack_q,   ack_d;
    logic                  ovf_q,   ovf_d;

    cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .d   (toggle_in[i]),
      .q   (tog_sync)
    );

    assign ev = tog_sync ^ prev_q;
    assign hs = valid_q & ready_in[i];

    // data_in is only sampled SYNC_STAGES cycles after its toggle: a multi-cycle/false path by design.
    always_comb begin
      prev_d  = tog_sync;
      valid_d = valid_q;
      data_d  = data_q;
      ack_d   = ack_q;
      ovf_d   = ovf_q & ~clr_ovf[i];
      if (ev) begin
        if (!valid_q) begin
          data_d  = data_in[i];
          valid_d = 1'b1;
        end else if (ready_in[i]) begin
          data_d = data_in[i];
          ack_d  = ~ack_q;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (hs) begin
        valid_d = 1'b0;
        ack_d   = ~ack_q;
      end
    end

    // prev tracks the synchronised level through reset so a held toggle raises no event on release.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q  <= tog_sync;
        valid_q <= 1'b0;
        data_q  <= '0;
        ack_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        prev_q  <= prev_d;
        valid_q <= valid_d;
        data_q  <= data_d;
        ack_q   <= ack_d;
        ovf_q   <= ovf_d;
      end
    end

    assign valid_out[i]  = valid_q;
    assign data_out[i]   = data_q;
    assign ack_toggle[i] = ack_q;
    assign overflow[i]   = ovf_q;
  end

endmodule : cdc_sync_bus_rx
